dmem_arbiter: RTL and testbench

//   Two-port arbiter and sequencer for the shared 128x32 data SRAM (CEN/WEN/OEN/A/D/Q, active-low controls).

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - cpu/dbg request ports and SRAM pins of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_cen;
  logic              mem_wen;
  logic              mem_oen;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic [DATA_W-1:0] mem_q;

  // slave: the arbiter itself
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_q,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_cen, mem_wen, mem_oen, mem_a, mem_d
  );

  // master: requesters plus the SRAM macro
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_q,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_cen, mem_wen, mem_oen, mem_a, mem_d
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin cpu/dbg arbiter and pipelined sequencer for the 128x32 data SRAM
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  owner_t            last_owner;
  owner_t            last_owner_nxt;
  logic              gnt_cpu;
  logic              gnt_dbg;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mem_cen_q;
  logic              mem_wen_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [DATA_W-1:0] mem_d_q;

  logic              tag1_vld;
  owner_t            tag1_own;
  logic              tag2_vld;
  owner_t            tag2_own;

  logic              cpu_rvalid_c;
  logic              dbg_rvalid_c;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_DBG;
    end else begin
      last_owner <= last_owner_nxt;
    end
  end

  // On conflict the port that did not win last time gets the slot.
  always_comb begin
    gnt_cpu        = 1'b0;
    gnt_dbg        = 1'b0;
    last_owner_nxt = last_owner;
    case ({bus.cpu_req, bus.dbg_req})
      2'b10: begin
        gnt_cpu        = 1'b1;
        last_owner_nxt = OWN_CPU;
      end
      2'b01: begin
        gnt_dbg        = 1'b1;
        last_owner_nxt = OWN_DBG;
      end
      2'b11: begin
        if (last_owner == OWN_CPU) begin
          gnt_dbg        = 1'b1;
          last_owner_nxt = OWN_DBG;
        end else begin
          gnt_cpu        = 1'b1;
          last_owner_nxt = OWN_CPU;
        end
      end
      default: begin
        gnt_cpu = 1'b0;
        gnt_dbg = 1'b0;
      end
    endcase
  end

  always_comb begin
    any_gnt   = gnt_cpu | gnt_dbg;
    sel_we    = gnt_dbg ? bus.dbg_we    : bus.cpu_we;
    sel_addr  = gnt_dbg ? bus.dbg_addr  : bus.cpu_addr;
    sel_wdata = gnt_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  end

  // Address and write data hold between accesses; only the strobes return idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cen_q <= 1'b1;
      mem_wen_q <= 1'b1;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
    end else if (any_gnt) begin
      mem_cen_q <= 1'b0;
      mem_wen_q <= ~sel_we;
      mem_a_q   <= sel_addr;
      mem_d_q   <= sel_wdata;
    end else begin
      mem_cen_q <= 1'b1;
      mem_wen_q <= 1'b1;
    end
  end

  // Two-stage owner tag follows each read to the cycle its data appears on mem_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_vld <= 1'b0;
      tag1_own <= OWN_CPU;
      tag2_vld <= 1'b0;
      tag2_own <= OWN_CPU;
    end else begin
      tag1_vld <= any_gnt & ~sel_we;
      tag1_own <= gnt_dbg ? OWN_DBG : OWN_CPU;
      tag2_vld <= tag1_vld;
      tag2_own <= tag1_own;
    end
  end

  always_comb begin
    cpu_rvalid_c = tag2_vld & (tag2_own == OWN_CPU);
    dbg_rvalid_c = tag2_vld & (tag2_own == OWN_DBG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_rvalid_c) begin
        cpu_rdata_q <= bus.mem_q;
      end
      if (dbg_rvalid_c) begin
        dbg_rdata_q <= bus.mem_q;
      end
    end
  end

  assign bus.cpu_gnt    = gnt_cpu;
  assign bus.dbg_gnt    = gnt_dbg;
  assign bus.cpu_stall  = bus.cpu_req & ~gnt_cpu;
  assign bus.cpu_rvalid = cpu_rvalid_c;
  assign bus.dbg_rvalid = dbg_rvalid_c;
  assign bus.cpu_rdata  = cpu_rvalid_c ? bus.mem_q : cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rvalid_c ? bus.mem_q : dbg_rdata_q;

  assign bus.mem_cen = mem_cen_q;
  assign bus.mem_wen = mem_wen_q;
  assign bus.mem_oen = 1'b0;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_d   = mem_d_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter with a behavioural 128x32 SRAM
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] sram [0:127];
  logic [31:0] sram_q;
  logic        sram_init = 1'b1;
  assign bus.mem_q = sram_q;

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 128; i++) sram[i] <= 32'h0;
      sram_init <= 1'b0;
    end else if (!bus.mem_cen) begin
      if (!bus.mem_wen) sram[bus.mem_a] <= bus.mem_d;
      else              sram_q <= sram[bus.mem_a];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_read(bit port, logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.due  = cyc + 2;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (bus.cpu_rvalid || bus.dbg_rvalid)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid_unexpected: cpu_rvalid=%0b dbg_rvalid=%0b, expected no return", bus.cpu_rvalid, bus.dbg_rvalid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rvalid_pair", {30'b0, bus.cpu_rvalid, bus.dbg_rvalid}, e.port ? 32'd1 : 32'd2);
        check("rdata", e.port ? bus.dbg_rdata : bus.cpu_rdata, e.data);
        check("rlatency", cyc, e.due);
      end
    end
  end

  task automatic set_req(bit port, bit req, bit we, logic [6:0] addr, logic [31:0] wdata);
    if (port) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  task automatic access(bit port, bit we, logic [6:0] addr, logic [31:0] wdata, logic [31:0] exp);
    bit got = 1'b0;
    @(posedge clk); #1;
    set_req(port, 1'b1, we, addr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port ? bus.dbg_gnt : bus.cpu_gnt) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gnt_timeout: port %0d not granted within 20 cycles", port);
    end else if (!we) begin
      push_read(port, exp);
    end
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, 7'd0, 32'h0);
  endtask

  task automatic drain;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d reads outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    set_req(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 7'd0, 32'h0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_cen", bus.mem_cen, 1);
    check("rst_mem_wen", bus.mem_wen, 1);
    check("rst_mem_oen", bus.mem_oen, 0);
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_mem_d", bus.mem_d, 0);
    check("rst_gnts", {bus.cpu_gnt, bus.dbg_gnt}, 0);
    check("rst_rvalids", {bus.cpu_rvalid, bus.dbg_rvalid}, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_dbg_rdata", bus.dbg_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // cpu write then read of addr 5
    access(1'b0, 1'b1, 7'd5, 32'h0000_00AA, 32'h0);
    access(1'b0, 1'b0, 7'd5, 32'h0, 32'h0000_00AA);
    drain();

    // simultaneous requests right after reset: cpu first, dbg one cycle later
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 7'd5, 32'h0);
    @(negedge clk);
    check("t2_c1_gnts", {bus.cpu_gnt, bus.dbg_gnt}, 2'b10);
    check("t2_c1_stall", bus.cpu_stall, 0);
    push_read(1'b0, 32'h0000_00AA);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
    @(negedge clk);
    check("t2_c2_gnts", {bus.cpu_gnt, bus.dbg_gnt}, 2'b01);
    push_read(1'b1, 32'h0000_00AA);
    @(posedge clk); #1 set_req(1'b1, 1'b0, 1'b0, 7'd0, 32'h0);
    drain();

    // both requesting for 8 cycles: strict alternation starting with cpu
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 7'd5, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_gnts", {bus.cpu_gnt, bus.dbg_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("t3_stall", bus.cpu_stall, (i % 2 == 0) ? 0 : 1);
      if (i > 0) check("t3_mem_cen", bus.mem_cen, 0);
      push_read((i % 2) != 0, 32'h0000_00AA);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 7'd0, 32'h0);
    @(negedge clk);
    check("t3_last_cen", bus.mem_cen, 0);
    drain();

    // dbg write to 127 immediately followed by cpu read of 127; addr 0 untouched
    @(posedge clk); #1 set_req(1'b1, 1'b1, 1'b1, 7'd127, 32'h1234_5678);
    @(negedge clk);
    check("t4_dbg_gnt", {bus.cpu_gnt, bus.dbg_gnt}, 2'b01);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b0, 7'd0, 32'h0);
    set_req(1'b0, 1'b1, 1'b0, 7'd127, 32'h0);
    @(negedge clk);
    check("t4_cpu_gnt", {bus.cpu_gnt, bus.dbg_gnt}, 2'b10);
    check("t4_issue_we", {bus.mem_cen, bus.mem_wen}, 2'b00);
    push_read(1'b0, 32'h1234_5678);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
    access(1'b1, 1'b0, 7'd0, 32'h0, 32'h0);
    drain();

    // reset in the cycle after a cpu read grant drops the read
    @(posedge clk); #1 set_req(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    @(negedge clk);
    check("t5_cpu_gnt", bus.cpu_gnt, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_mem_cen", bus.mem_cen, 1);
    check("t5_mem_wen", bus.mem_wen, 1);
    check("t5_mem_a", bus.mem_a, 0);
    check("t5_mem_d", bus.mem_d, 0);
    check("t5_rvalids", {bus.cpu_rvalid, bus.dbg_rvalid}, 0);
    check("t5_cpu_rdata", bus.cpu_rdata, 0);
    check("t5_dbg_rdata", bus.dbg_rdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_rvalid", {bus.cpu_rvalid, bus.dbg_rvalid}, 0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 7'd127, 32'h0);
    @(negedge clk);
    check("t5_owner_gnts", {bus.cpu_gnt, bus.dbg_gnt}, 2'b10);
    push_read(1'b0, 32'h0000_00AA);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
    @(negedge clk);
    check("t5_dbg_gnt", {bus.cpu_gnt, bus.dbg_gnt}, 2'b01);
    push_read(1'b1, 32'h1234_5678);
    @(posedge clk); #1 set_req(1'b1, 1'b0, 1'b0, 7'd0, 32'h0);

    // idle bus: strobes inactive, address holds the last issued value
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_cen_wen", {bus.mem_cen, bus.mem_wen}, 2'b11);
      check("t6_gnts", {bus.cpu_gnt, bus.dbg_gnt}, 0);
      check("t6_rvalids", {bus.cpu_rvalid, bus.dbg_rvalid}, 0);
      check("t6_mem_a", bus.mem_a, 127);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
